// File: rtl/mem_lsu.sv
// mem_lsu: MEM-stage load/store unit for the 5-stage MIPS pipeline.
// Drives an SRAM-like req/addr_ok/data_ok bus, steers store byte lanes,
// extends load data, and stalls the pipeline until the access completes.
// Optional feature macro: LSU_ADDR_EXC_EN enables alignment exceptions
// (adel/ades/badvaddr); when undefined they tie to 0 and misaligned
// half/word accesses issue with the low address bits ignored for steering.
module mem_lsu (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  mem_memop_i,
  input  logic [31:0] mem_aluout_i,
  input  logic [31:0] mem_rdata2_i,
  input  logic [31:0] mem_excepttype_i,
  input  logic        mem_flush_i,
  input  logic        mem_stall_i,
  output logic        data_req,
  output logic        data_wr,
  output logic [1:0]  data_size,
  output logic [31:0] data_addr,
  output logic [3:0]  data_wstrb,
  output logic [31:0] data_wdata,
  input  logic        data_addr_ok,
  input  logic        data_data_ok,
  input  logic [31:0] data_rdata,
  output logic [31:0] mem_wdata_o,
  output logic        mem_stall_o,
  output logic        mem_adel_o,
  output logic        mem_ades_o,
  output logic [31:0] mem_badvaddr_o
);

  typedef enum logic [2:0] {S_IDLE, S_REQ, S_WAIT, S_DONE, S_CANCEL} state_t;

  localparam logic [3:0] OP_LB  = 4'd1;
  localparam logic [3:0] OP_LBU = 4'd2;
  localparam logic [3:0] OP_LH  = 4'd3;
  localparam logic [3:0] OP_LHU = 4'd4;
  localparam logic [3:0] OP_LW  = 4'd5;
  localparam logic [3:0] OP_SB  = 4'd6;
  localparam logic [3:0] OP_SH  = 4'd7;
  localparam logic [3:0] OP_SW  = 4'd8;

  state_t      r_state, w_next;
  logic [31:0] r_addr, r_wdata, r_rdata;
  logic [3:0]  r_wstrb, r_op;
  logic [1:0]  r_size;
  logic        r_wr, r_flush_seen;

  logic        w_is_load, w_is_store, w_is_mem, w_aerr, w_want, w_new;
  logic [1:0]  w_size;
  logic [3:0]  w_wstrb;
  logic [31:0] w_wdata, w_ldata, w_shift;

  // Decode the incoming op: class, access size and store lane steering.
  always_comb begin
    w_is_load  = (mem_memop_i >= OP_LB) && (mem_memop_i <= OP_LW);
    w_is_store = (mem_memop_i >= OP_SB) && (mem_memop_i <= OP_SW);
    w_is_mem   = w_is_load | w_is_store;
    w_size     = 2'd2;
    w_wstrb    = 4'b0000;
    w_wdata    = 32'd0;
    case (mem_memop_i)
      OP_LB, OP_LBU: w_size = 2'd0;
      OP_LH, OP_LHU: w_size = 2'd1;
      OP_SB: begin
        w_size  = 2'd0;
        w_wstrb = 4'b0001 << mem_aluout_i[1:0];
        w_wdata = {4{mem_rdata2_i[7:0]}};
      end
      OP_SH: begin
        w_size  = 2'd1;
        w_wstrb = mem_aluout_i[1] ? 4'b1100 : 4'b0011;
        w_wdata = {2{mem_rdata2_i[15:0]}};
      end
      OP_SW: begin
        w_wstrb = 4'b1111;
        w_wdata = mem_rdata2_i;
      end
      default: ;
    endcase
  end

`ifdef LSU_ADDR_EXC_EN
  logic w_mis;
  // Alignment check; an upstream exception takes priority over this one.
  always_comb begin
    w_mis  = ((w_size == 2'd1) & mem_aluout_i[0]) |
             ((w_size == 2'd2) & (|mem_aluout_i[1:0]));
    w_aerr = w_is_mem & w_mis & (mem_excepttype_i == 32'd0);
  end
`else
  assign w_aerr = 1'b0;
`endif

  // An access the pipeline wants issued (may still be blocked by CANCEL).
  assign w_want = w_is_mem & (mem_excepttype_i == 32'd0) & ~mem_flush_i;
  assign w_new  = (r_state == S_IDLE) & w_want & ~w_aerr;

  // Load extraction from the captured word; half ignores addr[0], word ignores both.
  always_comb begin
    w_shift = r_rdata >> {r_addr[1:0], 3'b000};
    w_ldata = r_rdata;
    case (r_op)
      OP_LB:  w_ldata = {{24{w_shift[7]}}, w_shift[7:0]};
      OP_LBU: w_ldata = {24'd0, w_shift[7:0]};
      OP_LH:  w_ldata = r_addr[1] ? {{16{r_rdata[31]}}, r_rdata[31:16]}
                                  : {{16{r_rdata[15]}}, r_rdata[15:0]};
      OP_LHU: w_ldata = r_addr[1] ? {16'd0, r_rdata[31:16]} : {16'd0, r_rdata[15:0]};
      default: ;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_next;
  end

  // Next-state logic; a flush seen during REQ diverts the accepted request to CANCEL.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (w_new) w_next = data_addr_ok ? S_WAIT : S_REQ;
      S_REQ:    if (data_addr_ok) w_next = (r_flush_seen | mem_flush_i) ? S_CANCEL : S_WAIT;
      S_WAIT:   if (mem_flush_i) w_next = data_data_ok ? S_IDLE : S_CANCEL;
                else if (data_data_ok) w_next = S_DONE;
      S_DONE:   if (!mem_stall_i || mem_flush_i) w_next = S_IDLE;
      S_CANCEL: if (data_data_ok) w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  // Request latches, flush bookkeeping and read-data capture.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_addr       <= 32'd0;
      r_wdata      <= 32'd0;
      r_rdata      <= 32'd0;
      r_wstrb      <= 4'd0;
      r_op         <= 4'd0;
      r_size       <= 2'd0;
      r_wr         <= 1'b0;
      r_flush_seen <= 1'b0;
    end else begin
      if (w_new) begin
        r_addr       <= mem_aluout_i;
        r_wdata      <= w_wdata;
        r_wstrb      <= w_wstrb;
        r_op         <= mem_memop_i;
        r_size       <= w_size;
        r_wr         <= w_is_store;
        r_flush_seen <= 1'b0;
      end else if (r_state == S_REQ && mem_flush_i) begin
        r_flush_seen <= 1'b1;
      end
      if (r_state == S_WAIT && data_data_ok && !mem_flush_i)
        r_rdata <= data_rdata;
    end
  end

  // Outputs: bus fields, stall, stage result and address-error reporting.
  always_comb begin
    data_req       = 1'b0;
    data_wr        = 1'b0;
    data_size      = 2'd0;
    data_addr      = 32'd0;
    data_wstrb     = 4'd0;
    data_wdata     = 32'd0;
    mem_stall_o    = 1'b0;
    mem_wdata_o    = mem_aluout_i;
    mem_adel_o     = 1'b0;
    mem_ades_o     = 1'b0;
    mem_badvaddr_o = 32'd0;
    case (r_state)
      S_IDLE: begin
        if (w_new) begin
          data_req    = 1'b1;
          data_wr     = w_is_store;
          data_size   = w_size;
          data_addr   = mem_aluout_i;
          data_wstrb  = w_wstrb;
          data_wdata  = w_wdata;
          mem_stall_o = 1'b1;
        end
        mem_adel_o     = w_aerr & w_is_load;
        mem_ades_o     = w_aerr & w_is_store;
        mem_badvaddr_o = w_aerr ? mem_aluout_i : 32'd0;
      end
      S_REQ: begin
        data_req    = 1'b1;
        data_wr     = r_wr;
        data_size   = r_size;
        data_addr   = r_addr;
        data_wstrb  = r_wstrb;
        data_wdata  = r_wdata;
        mem_stall_o = 1'b1;
      end
      S_WAIT:   mem_stall_o = 1'b1;
      S_CANCEL: mem_stall_o = w_want;
      S_DONE:   if (!r_wr) mem_wdata_o = w_ldata;
      default: ;
    endcase
    // Reset forces every output low immediately, even for pass-through paths.
    if (!rst) begin
      data_req       = 1'b0;
      data_wr        = 1'b0;
      data_size      = 2'd0;
      data_addr      = 32'd0;
      data_wstrb     = 4'd0;
      data_wdata     = 32'd0;
      mem_stall_o    = 1'b0;
      mem_wdata_o    = 32'd0;
      mem_adel_o     = 1'b0;
      mem_ades_o     = 1'b0;
      mem_badvaddr_o = 32'd0;
    end
  end

endmodule

// File: tb/tb_mem_lsu.sv
// Testbench for mem_lsu: directed and random accesses against an
// arithmetic reference model of lane steering, load extension and stall timing.
module tb_mem_lsu;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [3:0]  mem_memop_i = 4'd0;
  logic [31:0] mem_aluout_i = 32'd0, mem_rdata2_i = 32'd0, mem_excepttype_i = 32'd0;
  logic        mem_flush_i = 1'b0, mem_stall_i = 1'b0;
  logic        data_req, data_wr;
  logic [1:0]  data_size;
  logic [31:0] data_addr, data_wdata;
  logic [3:0]  data_wstrb;
  logic        data_addr_ok = 1'b0, data_data_ok = 1'b0;
  logic [31:0] data_rdata = 32'd0;
  logic [31:0] mem_wdata_o, mem_badvaddr_o;
  logic        mem_stall_o, mem_adel_o, mem_ades_o;

  int total = 0;
  int bad = 0;

  mem_lsu dut (
    .clk(clk), .rst(rst),
    .mem_memop_i(mem_memop_i), .mem_aluout_i(mem_aluout_i), .mem_rdata2_i(mem_rdata2_i),
    .mem_excepttype_i(mem_excepttype_i), .mem_flush_i(mem_flush_i), .mem_stall_i(mem_stall_i),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size), .data_addr(data_addr),
    .data_wstrb(data_wstrb), .data_wdata(data_wdata), .data_addr_ok(data_addr_ok),
    .data_data_ok(data_data_ok), .data_rdata(data_rdata), .mem_wdata_o(mem_wdata_o),
    .mem_stall_o(mem_stall_o), .mem_adel_o(mem_adel_o), .mem_ades_o(mem_ades_o),
    .mem_badvaddr_o(mem_badvaddr_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
    end
  endtask

  // Reference model: bytes per access for each op.
  function automatic int m_bytes(input logic [3:0] op);
    case (op)
      4'd1, 4'd2, 4'd6: return 1;
      4'd3, 4'd4, 4'd7: return 2;
      default:          return 4;
    endcase
  endfunction

  function automatic logic [31:0] m_size(input logic [3:0] op);
    return (m_bytes(op) == 1) ? 0 : (m_bytes(op) == 2) ? 1 : 2;
  endfunction

  // Lane offset in bytes: byte uses addr%4, half uses bit 1 only, word none.
  function automatic int m_lane(input logic [3:0] op, input logic [31:0] a);
    if (m_bytes(op) == 1) return int'(a % 4);
    if (m_bytes(op) == 2) return ((a / 2) % 2 == 1) ? 2 : 0;
    return 0;
  endfunction

  function automatic logic [31:0] m_wstrb(input logic [3:0] op, input logic [31:0] a);
    if (op < 6 || op > 8) return 0;
    return ((1 << m_bytes(op)) - 1) << m_lane(op, a);
  endfunction

  function automatic logic [31:0] m_wdata(input logic [3:0] op, input logic [31:0] rt);
    if (op == 6) return (rt % 256) * 32'h0101_0101;
    if (op == 7) return (rt % 65536) * 32'h0001_0001;
    return rt;
  endfunction

  function automatic logic [31:0] m_load(input logic [3:0] op, input logic [31:0] a, input logic [31:0] rd);
    logic [31:0] v;
    v = rd / (32'd1 << (8 * m_lane(op, a)));
    case (op)
      4'd1: begin v = v % 256;   return (v >= 128)   ? v + 32'hFFFF_FF00 : v; end
      4'd2: return v % 256;
      4'd3: begin v = v % 65536; return (v >= 32768) ? v + 32'hFFFF_0000 : v; end
      4'd4: return v % 65536;
      default: return rd;
    endcase
  endfunction

  // One access from IDLE: addr_ok after ad wait cycles, data_ok dd cycles later,
  // then the result held in DONE for hold extra cycles. Starts and ends at posedge+1.
  task automatic run_access(input logic [3:0] op, input logic [31:0] a, input logic [31:0] rt,
                            input logic [31:0] rd, input int ad, input int dd, input int hold);
    logic [31:0] exp_res;
    logic        is_st;
    is_st   = (op >= 6);
    exp_res = is_st ? a : m_load(op, a, rd);
    mem_memop_i = op; mem_aluout_i = a; mem_rdata2_i = rt;
    for (int c = 0; c <= ad + dd + 1; c++) begin
      data_addr_ok = (c == ad);
      data_data_ok = (c == ad + dd);
      data_rdata   = (c == ad + dd) ? rd : $urandom;
      @(negedge clk);
      if (c == ad + dd + 1) break;
      chk("stall_busy", mem_stall_o, 1);
      chk("req", data_req, (c <= ad) ? 1 : 0);
      if (c <= ad) begin
        chk("wr", data_wr, is_st);
        chk("size", data_size, m_size(op));
        chk("addr", data_addr, a);
        chk("wstrb", data_wstrb, m_wstrb(op, a));
        if (is_st) chk("wdata", data_wdata, m_wdata(op, rt));
        chk("no_exc", {mem_adel_o, mem_ades_o}, 0);
      end
      @(posedge clk); #1;
    end
    chk("done_stall", mem_stall_o, 0);
    chk("done_req", data_req, 0);
    chk("result", mem_wdata_o, exp_res);
    mem_stall_i = 1'b1;
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #1;
      @(negedge clk);
      chk("hold_req", data_req, 0);
      chk("hold_stall", mem_stall_o, 0);
      chk("hold_result", mem_wdata_o, exp_res);
    end
    mem_stall_i = 1'b0;
    @(posedge clk); #1;
    mem_memop_i = 4'd0;
    data_rdata  = 32'd0;
  endtask

  initial begin
    logic [3:0]  op;
    logic [31:0] a;
    mem_aluout_i = 32'h1234_5678;
    mem_memop_i  = 4'd5;
    #3;
    chk("rst_req", data_req, 0);
    chk("rst_stall", mem_stall_o, 0);
    chk("rst_result", mem_wdata_o, 0);
    chk("rst_badv", mem_badvaddr_o, 0);
    mem_memop_i = 4'd0;
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;

    // Loads and stores on a single-cycle bus.
    run_access(4'd5, 32'h1000_0004, 32'h0, 32'hDEAD_BEEF, 0, 1, 0);
    run_access(4'd1, 32'h1000_0003, 32'h0, 32'h80FF_0000, 0, 1, 0);
    run_access(4'd2, 32'h1000_0003, 32'h0, 32'h80FF_0000, 0, 1, 0);
    run_access(4'd3, 32'h1000_0002, 32'h0, 32'h9ABC_1234, 0, 1, 0);
    run_access(4'd4, 32'h1000_0000, 32'h0, 32'h1234_F00D, 0, 1, 0);
    run_access(4'd6, 32'h1000_0001, 32'hAABB_CCDD, 32'h0, 0, 1, 0);
    // SH with addr_ok delayed 3 cycles: request must stay stable.
    run_access(4'd7, 32'h1000_0002, 32'h1234_5678, 32'h0, 3, 1, 0);
    run_access(4'd8, 32'h1000_0008, 32'hCAFE_F00D, 32'h0, 1, 2, 0);
    // DONE held by downstream stall.
    run_access(4'd5, 32'h2000_0010, 32'h0, 32'h0BAD_CAFE, 0, 2, 4);

    // Non-memop, reserved op and upstream exception all pass aluout through.
    mem_memop_i = 4'd0; mem_aluout_i = 32'h5555_AAAA;
    @(negedge clk);
    chk("none_req", data_req, 0); chk("none_stall", mem_stall_o, 0);
    chk("none_result", mem_wdata_o, 32'h5555_AAAA);
    @(posedge clk); #1; mem_memop_i = 4'd13;
    @(negedge clk);
    chk("rsvd_req", data_req, 0); chk("rsvd_result", mem_wdata_o, 32'h5555_AAAA);
    @(posedge clk); #1; mem_memop_i = 4'd5; mem_excepttype_i = 32'h10;
    @(negedge clk);
    chk("exc_req", data_req, 0); chk("exc_stall", mem_stall_o, 0);
    chk("exc_result", mem_wdata_o, 32'h5555_AAAA);
    @(posedge clk); #1; mem_excepttype_i = 32'd0; mem_memop_i = 4'd0;

    // Misaligned accesses.
`ifdef LSU_ADDR_EXC_EN
    mem_memop_i = 4'd5; mem_aluout_i = 32'h1000_0001;
    @(negedge clk);
    chk("adel", mem_adel_o, 1); chk("adel_ades", mem_ades_o, 0);
    chk("adel_badv", mem_badvaddr_o, 32'h1000_0001);
    chk("adel_req", data_req, 0); chk("adel_stall", mem_stall_o, 0);
    @(posedge clk); #1; mem_memop_i = 4'd7; mem_aluout_i = 32'h1000_0003;
    @(negedge clk);
    chk("ades", mem_ades_o, 1); chk("ades_adel", mem_adel_o, 0);
    chk("ades_badv", mem_badvaddr_o, 32'h1000_0003); chk("ades_req", data_req, 0);
    @(posedge clk); #1; mem_memop_i = 4'd0;
`else
    run_access(4'd5, 32'h1000_0001, 32'h0, 32'hCAFE_F00D, 0, 1, 0);
    run_access(4'd7, 32'h1000_0003, 32'h0000_BEEF, 32'h0, 0, 1, 0);
    run_access(4'd3, 32'h1000_0003, 32'h0, 32'h8001_7FFF, 0, 1, 0);
`endif

    // Flush in WAIT, response 2 cycles later, next load pending meanwhile.
    mem_memop_i = 4'd5; mem_aluout_i = 32'h3000_0000; data_addr_ok = 1'b1;
    @(negedge clk); chk("fw_req", data_req, 1);
    @(posedge clk); #1; data_addr_ok = 1'b0; mem_flush_i = 1'b1;
    @(negedge clk); chk("fw_stall", mem_stall_o, 1);
    @(posedge clk); #1; mem_flush_i = 1'b0; mem_aluout_i = 32'h3000_0004;
    @(negedge clk); chk("fw_cancel_req", data_req, 0); chk("fw_cancel_stall", mem_stall_o, 1);
    @(posedge clk); #1; data_data_ok = 1'b1; data_rdata = 32'hFFFF_FFFF;
    @(negedge clk); chk("fw_drop_req", data_req, 0); chk("fw_drop_stall", mem_stall_o, 1);
    @(posedge clk); #1; data_data_ok = 1'b0;
    run_access(4'd5, 32'h3000_0004, 32'h0, 32'h2222_3333, 0, 1, 0);

    // Flush together with data_ok in WAIT: straight back to IDLE, data dropped.
    mem_memop_i = 4'd5; mem_aluout_i = 32'h3000_0008; data_addr_ok = 1'b1;
    @(posedge clk); #1; data_addr_ok = 1'b0; mem_flush_i = 1'b1;
    data_data_ok = 1'b1; data_rdata = 32'h7777_7777;
    @(posedge clk); #1; mem_flush_i = 1'b0; data_data_ok = 1'b0; mem_memop_i = 4'd0;
    @(negedge clk);
    chk("fwd_stall", mem_stall_o, 0); chk("fwd_result", mem_wdata_o, 32'h3000_0008);
    @(posedge clk); #1;

    // Flush in REQ, then addr_ok: CANCEL with no pending op, stall drops.
    mem_memop_i = 4'd8; mem_aluout_i = 32'h3000_0010; mem_rdata2_i = 32'h1;
    @(posedge clk); #1; mem_flush_i = 1'b1;
    @(negedge clk); chk("fr_req", data_req, 1); chk("fr_stall", mem_stall_o, 1);
    @(posedge clk); #1; mem_flush_i = 1'b0; mem_memop_i = 4'd0; data_addr_ok = 1'b1;
    @(posedge clk); #1; data_addr_ok = 1'b0; data_data_ok = 1'b1;
    @(negedge clk); chk("fr_cancel_req", data_req, 0); chk("fr_cancel_stall", mem_stall_o, 0);
    @(posedge clk); #1; data_data_ok = 1'b0;

    // Random aligned accesses with random bus latency.
    for (int n = 0; n < 24; n++) begin
      op = 4'($urandom_range(1, 8));
      a  = $urandom;
      if (m_bytes(op) == 2) a[0] = 1'b0;
      if (m_bytes(op) == 4) a[1:0] = 2'b00;
      run_access(op, a, $urandom, $urandom, $urandom_range(0, 3), $urandom_range(1, 3),
                 $urandom_range(0, 2));
    end

    // Async reset mid-WAIT forces every output to 0 at once.
    mem_memop_i = 4'd5; mem_aluout_i = 32'h4000_0000; data_addr_ok = 1'b1;
    @(posedge clk); #1; data_addr_ok = 1'b0;
    #1 rst = 1'b0;
    #1;
    chk("arst_stall", mem_stall_o, 0);
    chk("arst_req", data_req, 0);
    chk("arst_result", mem_wdata_o, 0);
    @(negedge clk); mem_memop_i = 4'd0; rst = 1'b1;
    @(posedge clk); #1;
    run_access(4'd2, 32'h4000_0001, 32'h0, 32'h0000_C300, 0, 1, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end
endmodule
